// File: rtl/alu_muldiv_ctrl_pkg.sv
// alu_muldiv_ctrl_pkg: shared constants for the EX-stage ALU decoder and the
// iterative RV32M engine. It holds the alu_op encodings, the opcode, funct3
// and funct7 constants, the M-op funct3 codes and the engine state encoding.
package alu_muldiv_ctrl_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ALU_OP_W = 4;

  // ALU operation encodings
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_AND    = 4'b0100,
    ALU_OR     = 4'b0101,
    ALU_XOR    = 4'b1000,
    ALU_SLL    = 4'b1010,
    ALU_SRL    = 4'b1011,
    ALU_SRA    = 4'b1100,
    ALU_SLT    = 4'b1101,
    ALU_SLTU   = 4'b1110,
    ALU_PASS_B = 4'b1111
  } alu_op_e;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LOAD       = 7'b0000011;
  localparam logic [6:0] OPC_ARITH_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC      = 7'b0010111;
  localparam logic [6:0] OPC_STORE      = 7'b0100011;
  localparam logic [6:0] OPC_ARITH      = 7'b0110011;
  localparam logic [6:0] OPC_LUI        = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH     = 7'b1100011;
  localparam logic [6:0] OPC_JALR       = 7'b1100111;
  localparam logic [6:0] OPC_JAL        = 7'b1101111;

  // Arithmetic funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct7
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [6:0] FUNCT7_SRA    = 7'b0100000;
  localparam logic [6:0] FUNCT7_SUB    = 7'b0100000;

  // M-extension funct3
  localparam logic [2:0] M_MUL    = 3'b000;
  localparam logic [2:0] M_MULH   = 3'b001;
  localparam logic [2:0] M_MULHSU = 3'b010;
  localparam logic [2:0] M_MULHU  = 3'b011;
  localparam logic [2:0] M_DIV    = 3'b100;
  localparam logic [2:0] M_DIVU   = 3'b101;
  localparam logic [2:0] M_REM    = 3'b110;
  localparam logic [2:0] M_REMU   = 3'b111;

  // Multiply/divide engine states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

endpackage

// File: rtl/alu_muldiv_ctrl_muldiv_iter.sv
// alu_muldiv_ctrl_muldiv_iter: iterative RV32M engine.
// The engine uses XLEN shift-add steps for multiply and XLEN restoring steps
// for divide. Each step works on a 2*XLEN accumulator, and one FIX cycle then
// applies the sign and selects the result word.
// Ports: clk, reset (async active-low), start_i (accept this cycle),
//        flush_i (abort), funct3_i/rs1_i/rs2_i (M-op and operands),
//        idle_o (state IDLE), busy_o (MUL/DIV/FIX), md_valid_o (1-cycle
//        result pulse), md_result_o (held result).
module alu_muldiv_ctrl_muldiv_iter
  import alu_muldiv_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            idle_o,
  output logic            busy_o,
  output logic            md_valid_o,
  output logic [XLEN-1:0] md_result_o
);

  localparam int unsigned CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam int unsigned ACC_W = 2 * XLEN;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [XLEN-1:0]  opb_q, opb_d;      // multiplicand / divisor magnitude
  logic [2:0]       f3_q, f3_d;
  logic             neg_q, neg_d;      // final result must be negated
  logic             md_valid_q, md_valid_d;
  logic [XLEN-1:0]  res_q, res_d;

  // Accept-time operand conditioning and fast-path detection
  logic            is_div_op, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;
  logic            div_zero, div_ovf;

  always_comb begin
    is_div_op = funct3_i[2];
    a_signed  = (funct3_i == M_MUL) || (funct3_i == M_MULH) ||
                (funct3_i == M_MULHSU) || (funct3_i == M_DIV) ||
                (funct3_i == M_REM);
    b_signed  = (funct3_i == M_MUL) || (funct3_i == M_MULH) ||
                (funct3_i == M_DIV) || (funct3_i == M_REM);
    a_neg     = a_signed && rs1_i[XLEN-1];
    b_neg     = b_signed && rs2_i[XLEN-1];
    a_mag     = a_neg ? (~rs1_i + XLEN'(1)) : rs1_i;
    b_mag     = b_neg ? (~rs2_i + XLEN'(1)) : rs2_i;
    div_zero  = is_div_op && (rs2_i == '0);
    div_ovf   = ((funct3_i == M_DIV) || (funct3_i == M_REM)) &&
                (rs1_i == MOST_NEG) && (rs2_i == '1);
    // funct3[1] separates REM/REMU from DIV/DIVU
    if (div_zero) begin
      fast_res = funct3_i[1] ? rs1_i : '1;
    end else begin
      fast_res = funct3_i[1] ? '0 : rs1_i;
    end
  end

  // One shift-add or restoring-divide step on the accumulator
  logic [XLEN:0]    mul_sum, div_rem_sh, div_diff;
  logic [ACC_W-1:0] mul_next, div_next;

  always_comb begin
    mul_sum    = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next   = {mul_sum, acc_q[XLEN-1:1]};
    div_rem_sh = acc_q[ACC_W-1:XLEN-1];
    div_diff   = div_rem_sh - {1'b0, opb_q};
    if (div_diff[XLEN]) begin
      div_next = {div_rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  // Sign fix and result word selection
  logic [ACC_W-1:0] prod;
  logic [XLEN-1:0]  div_sel, div_fix, fix_res;

  always_comb begin
    prod    = neg_q ? (~acc_q + ACC_W'(1)) : acc_q;
    div_sel = f3_q[1] ? acc_q[ACC_W-1:XLEN] : acc_q[XLEN-1:0];
    div_fix = neg_q ? (~div_sel + XLEN'(1)) : div_sel;
    if (f3_q[2]) begin
      fix_res = div_fix;
    end else if (f3_q == M_MUL) begin
      fix_res = prod[XLEN-1:0];
    end else begin
      fix_res = prod[ACC_W-1:XLEN];
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    f3_d       = f3_q;
    neg_d      = neg_q;
    md_valid_d = 1'b0;
    res_d      = res_q;
    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            f3_d  = funct3_i;
            // remainder follows the dividend; everything else is sign(a)^sign(b)
            neg_d = (funct3_i == M_REM) ? a_neg : (a_neg ^ b_neg);
            opb_d = b_mag;
            acc_d = {{XLEN{1'b0}}, a_mag};
            cnt_d = '0;
            if (div_zero || div_ovf) begin
              state_d    = ST_DONE;
              res_d      = fast_res;
              md_valid_d = 1'b1;
            end else begin
              state_d = is_div_op ? ST_DIV : ST_MUL;
            end
          end
        end
        ST_MUL: begin
          acc_d = mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_FIX;
            cnt_d   = '0;
          end
        end
        ST_DIV: begin
          acc_d = div_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_FIX;
            cnt_d   = '0;
          end
        end
        ST_FIX: begin
          res_d      = fix_res;
          md_valid_d = 1'b1;
          state_d    = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      f3_q       <= '0;
      neg_q      <= 1'b0;
      md_valid_q <= 1'b0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      f3_q       <= f3_d;
      neg_q      <= neg_d;
      md_valid_q <= md_valid_d;
      res_q      <= res_d;
    end
  end

  assign idle_o      = (state_q == ST_IDLE);
  assign busy_o      = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
  assign md_valid_o  = md_valid_q;
  assign md_result_o = res_q;

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// alu_muldiv_ctrl: EX-stage ALU control decoder with an iterative RV32M engine.
// Ports: clk, reset (async active-low), inst/in_valid/rs1_data/rs2_data
//        (EX instruction and operands), flush (abort M-op), in_ready
//        (engine idle), alu_op (combinational ALU op), is_muldiv
//        (combinational M-op decode), stall (hold IF/ID/EX), md_valid
//        (1-cycle result pulse), md_result (M-op result).
module alu_muldiv_ctrl
  import alu_muldiv_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INST_W-1:0] inst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              flush,
  output logic [OP_W-1:0]   alu_op,
  output logic              is_muldiv,
  output logic              stall,
  output logic              md_valid,
  output logic [XLEN-1:0]   md_result
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  alu_op_e    op_c;
  logic       unused_inst;

  assign opcode      = inst[6:0];
  assign funct3      = inst[14:12];
  assign funct7      = inst[31:25];
  assign unused_inst = ^{inst[24:15], inst[11:7]};

  // RV32I ALU-op decode; unknown opcodes and funct3 fall back to ADD
  always_comb begin
    op_c = ALU_ADD;
    case (opcode)
      OPC_ARITH, OPC_ARITH_IMM: begin
        case (funct3)
          F3_ADD:  op_c = ((opcode == OPC_ARITH) && (funct7 == FUNCT7_SUB)) ? ALU_SUB : ALU_ADD;
          F3_SLL:  op_c = ALU_SLL;
          F3_SLT:  op_c = ALU_SLT;
          F3_SLTU: op_c = ALU_SLTU;
          F3_XOR:  op_c = ALU_XOR;
          // inst[30] selects arithmetic shift for both R and I forms
          F3_SR:   op_c = funct7[5] ? ALU_SRA : ALU_SRL;
          F3_OR:   op_c = ALU_OR;
          F3_AND:  op_c = ALU_AND;
          default: op_c = ALU_ADD;
        endcase
      end
      OPC_LUI: op_c = ALU_PASS_B;
      OPC_BRANCH: begin
        case (funct3)
          F3_BEQ, F3_BNE:   op_c = ALU_SUB;
          F3_BLT, F3_BGE:   op_c = ALU_SLT;
          F3_BLTU, F3_BGEU: op_c = ALU_SLTU;
          default:          op_c = ALU_ADD;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JALR, OPC_JAL, OPC_AUIPC: op_c = ALU_ADD;
      default: op_c = ALU_ADD;
    endcase
  end

  assign alu_op    = OP_W'(op_c);
  assign is_muldiv = (opcode == OPC_ARITH) && (funct7 == FUNCT7_MULDIV);

  logic md_idle, md_busy, md_start;

  assign md_start = in_valid && is_muldiv && md_idle && !flush;

  alu_muldiv_ctrl_muldiv_iter #(
    .XLEN (XLEN)
  ) u_muldiv_iter (
    .clk         (clk),
    .reset       (reset),
    .start_i     (md_start),
    .flush_i     (flush),
    .funct3_i    (funct3),
    .rs1_i       (rs1_data),
    .rs2_i       (rs2_data),
    .idle_o      (md_idle),
    .busy_o      (md_busy),
    .md_valid_o  (md_valid),
    .md_result_o (md_result)
  );

  // Stall drops in DONE so the pipeline retires the M-op on that edge
  assign stall    = md_busy || (md_idle && in_valid && is_muldiv);
  assign in_ready = md_idle;

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// tb_alu_muldiv_ctrl: table-driven decode vectors plus directed M-op sequences.
module tb_alu_muldiv_ctrl;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 4;
  localparam logic [6:0] OP   = 7'b0110011;
  localparam logic [6:0] OPI  = 7'b0010011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BAD  = 7'b1111111;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     inst;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic [OP_W-1:0] alu_op;
  logic            is_muldiv;
  logic            stall;
  logic            md_valid;
  logic [XLEN-1:0] md_result;

  int n_chk  = 0;
  int n_fail = 0;

  alu_muldiv_ctrl #(.XLEN(XLEN), .OP_W(OP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .inst      (inst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .flush     (flush),
    .alu_op    (alu_op),
    .is_muldiv (is_muldiv),
    .stall     (stall),
    .md_valid  (md_valid),
    .md_result (md_result)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] inst;
    logic        vld;
    logic [3:0]  exp_op;
    logic        exp_md;
  } vec_t;

  vec_t tv[$];

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one M-op, hold it while stalled, check latency, stall span and result
  task automatic run_mop(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int k;
    int stalls;
    inst     = rtype(7'b0000001, f3, OP);
    rs1_data = a;
    rs2_data = b;
    in_valid = 1'b1;
    #1;
    k      = 0;
    stalls = 0;
    chk({name, " ready"}, 32'(in_ready), 32'd1);
    if (stall) stalls++;
    while (k < 80) begin
      tick();
      k++;
      if (md_valid) break;
      if (stall) stalls++;
    end
    chk({name, " latency"}, 32'(k), 32'(exp_lat));
    chk({name, " stall_cycles"}, 32'(stalls), 32'(exp_lat));
    chk({name, " result"}, md_result, exp_res);
    chk({name, " stall_in_done"}, 32'(stall), 32'd0);
    in_valid = 1'b0;
    tick();
    chk({name, " valid_pulse"}, 32'(md_valid), 32'd0);
    chk({name, " back_idle"}, 32'(in_ready), 32'd1);
    chk({name, " result_hold"}, md_result, exp_res);
  endtask

  initial begin
    int seen;

    tv.push_back('{rtype(7'h00, 3'd0, OP),  1'b1, 4'b0000, 1'b0}); // ADD
    tv.push_back('{rtype(7'h20, 3'd0, OP),  1'b1, 4'b0001, 1'b0}); // SUB
    tv.push_back('{rtype(7'h20, 3'd5, OP),  1'b1, 4'b1100, 1'b0}); // SRA
    tv.push_back('{rtype(7'h20, 3'd5, OPI), 1'b1, 4'b1100, 1'b0}); // SRAI
    tv.push_back('{rtype(7'h00, 3'd5, OPI), 1'b1, 4'b1011, 1'b0}); // SRLI
    tv.push_back('{rtype(7'h00, 3'd3, OP),  1'b1, 4'b1110, 1'b0}); // SLTU
    tv.push_back('{rtype(7'h00, 3'd2, OP),  1'b1, 4'b1101, 1'b0}); // SLT
    tv.push_back('{rtype(7'h00, 3'd4, OPI), 1'b1, 4'b1000, 1'b0}); // XORI
    tv.push_back('{rtype(7'h00, 3'd6, OP),  1'b1, 4'b0101, 1'b0}); // OR
    tv.push_back('{rtype(7'h00, 3'd7, OP),  1'b1, 4'b0100, 1'b0}); // AND
    tv.push_back('{rtype(7'h00, 3'd1, OP),  1'b1, 4'b1010, 1'b0}); // SLL
    tv.push_back('{rtype(7'h20, 3'd0, OPI), 1'b1, 4'b0000, 1'b0}); // ADDI, imm[10] set
    tv.push_back('{rtype(7'h12, 3'd3, LUI), 1'b1, 4'b1111, 1'b0}); // LUI
    tv.push_back('{rtype(7'h00, 3'd6, BR),  1'b1, 4'b1110, 1'b0}); // BLTU
    tv.push_back('{rtype(7'h00, 3'd0, BR),  1'b1, 4'b0001, 1'b0}); // BEQ
    tv.push_back('{rtype(7'h00, 3'd5, BR),  1'b1, 4'b1101, 1'b0}); // BGE
    tv.push_back('{rtype(7'h00, 3'd2, BR),  1'b1, 4'b0000, 1'b0}); // illegal branch funct3
    tv.push_back('{rtype(7'h00, 3'd2, LD),  1'b1, 4'b0000, 1'b0}); // LW
    tv.push_back('{rtype(7'h55, 3'd4, JAL), 1'b1, 4'b0000, 1'b0}); // JAL
    tv.push_back('{rtype(7'h00, 3'd4, BAD), 1'b1, 4'b0000, 1'b0}); // unknown opcode
    tv.push_back('{rtype(7'h01, 3'd0, OP),  1'b0, 4'b0000, 1'b1}); // MUL, not valid

    reset    = 1'b0;
    inst     = '0;
    in_valid = 1'b0;
    rs1_data = '0;
    rs2_data = '0;
    flush    = 1'b0;
    repeat (2) tick();
    chk("rst ready", 32'(in_ready), 32'd1);
    chk("rst md_valid", 32'(md_valid), 32'd0);
    chk("rst md_result", md_result, 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    reset = 1'b1;
    tick();

    foreach (tv[i]) begin
      inst     = tv[i].inst;
      in_valid = tv[i].vld;
      #1;
      chk($sformatf("vec%0d alu_op", i), 32'(alu_op), 32'(tv[i].exp_op));
      chk($sformatf("vec%0d is_muldiv", i), 32'(is_muldiv), 32'(tv[i].exp_md));
      chk($sformatf("vec%0d stall", i), 32'(stall), 32'(tv[i].vld && tv[i].exp_md));
      tick();
      chk($sformatf("vec%0d md_valid", i), 32'(md_valid), 32'd0);
      chk($sformatf("vec%0d ready", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();

    run_mop("mul",      3'd0, 32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 34);
    run_mop("mulhu",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run_mop("mulhsu",   3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34);
    run_mop("div",      3'd4, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFD, 34);
    run_mop("rem",      3'd6, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFE, 34);
    run_mop("divu_z",   3'd5, 32'h80000000, 32'd0,        32'hFFFFFFFF, 1);
    run_mop("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_mop("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    run_mop("rem_z",    3'd6, 32'h12345678, 32'd0,        32'h12345678, 1);
    run_mop("divu",     3'd5, 32'd100,      32'd7,        32'd14,       34);
    run_mop("mulh_min", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34);

    // Flush ten cycles into a DIV
    inst     = rtype(7'b0000001, 3'd4, OP);
    rs1_data = 32'hFFFFFFEC;
    rs2_data = 32'd6;
    in_valid = 1'b1;
    seen     = 0;
    repeat (10) begin
      tick();
      if (md_valid) seen++;
    end
    flush    = 1'b1;
    in_valid = 1'b0;
    tick();
    flush = 1'b0;
    chk("flush ready", 32'(in_ready), 32'd1);
    chk("flush stall", 32'(stall), 32'd0);
    repeat (40) begin
      tick();
      if (md_valid) seen++;
    end
    chk("flush no_valid", 32'(seen), 32'd0);
    chk("flush result_hold", md_result, 32'h40000000);

    // Flush in the accept cycle suppresses the accept
    inst     = rtype(7'b0000001, 3'd0, OP);
    rs1_data = 32'd3;
    rs2_data = 32'd5;
    in_valid = 1'b1;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("acc_flush ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (40) begin
      tick();
      if (md_valid) seen++;
    end
    chk("acc_flush no_valid", 32'(seen), 32'd0);

    // Asynchronous reset mid-MUL
    inst     = rtype(7'b0000001, 3'd0, OP);
    rs1_data = 32'd9;
    rs2_data = 32'd9;
    in_valid = 1'b1;
    repeat (5) tick();
    chk("mid_mul busy", 32'(in_ready), 32'd0);
    #2;
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("async_rst ready", 32'(in_ready), 32'd1);
    chk("async_rst md_valid", 32'(md_valid), 32'd0);
    chk("async_rst md_result", md_result, 32'd0);
    chk("async_rst stall", 32'(stall), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    run_mop("mul_after_rst", 3'd0, 32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_ctrl.md
Name: alu_muldiv_ctrl

Overview:
- Parametrised successor of the EX-stage ALU control decoder.
- Decodes the full RV32I ALU-op set, including SRA/SLT/SLTU/LUI and unsigned branches, and adds an iterative RV32M multiply/divide engine with a pipeline stall handshake.
- Sits in EX beside the ALU.
- Single-cycle ops get a combinational alu_op; M-extension ops are accepted, computed over XLEN+2 cycles, and returned on md_result while the pipeline stalls.

Parameters:
- XLEN, 32, datapath width in bits; operand and result width.
- OP_W, 4, alu_op encoding width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; low forces reset state immediately.
- inst  in  32  EX-stage instruction word.
- in_valid  in  1  inst/rs1_data/rs2_data valid this cycle.
- in_ready  out  1  engine can accept an M-op (state IDLE).
- rs1_data  in  XLEN  operand A.
- rs2_data  in  XLEN  operand B.
- flush  in  1  abort the in-flight M-op (branch mispredict/trap).
- alu_op  out  OP_W  combinational ALU operation for non-M instructions.
- is_muldiv  out  1  combinational: opcode ARITHMETIC and funct7=0000001.
- stall  out  1  hold IF/ID/EX; do not advance the M-op.
- md_valid  out  1  one-cycle pulse; md_result valid.
- md_result  out  XLEN  M-op result.

Behaviour:
- alu_op decode, combinational:
  - ARITHMETIC/ARITHMETIC_IMM by funct3: ADD (SUB only when R-type and funct7=0100000), SLL, SLT, SLTU, XOR, SRL/SRA (funct7[5]=1 gives SRA, both R and I), OR, AND.
  - LOAD/STORE/JALR/JAL/AUIPC give ADD; LUI gives PASS_B.
  - BRANCH: BEQ/BNE give SUB; BLT/BGE give SLT; BLTU/BGEU give SLTU.
  - Any other opcode or funct3 gives ADD; no latch.
- Encodings: ADD 0000, SUB 0001, AND 0100, OR 0101, XOR 1000, SLL 1010, SRL 1011, SRA 1100, SLT 1101, SLTU 1110, PASS_B 1111.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
  - Accept when in_valid && is_muldiv && state==IDLE && !flush.
  - On accept, latch funct3, operand magnitudes and result sign.
  - MUL (funct3 0-3): XLEN shift-add iterations on a 2*XLEN accumulator.
  - DIV (funct3 4-7): XLEN restoring iterations.
  - Iteration counter counts 0..XLEN-1; the last iteration goes to FIX.
  - FIX: conditional two's-complement negate, then select low/high word or quotient/remainder; next state DONE.
  - DONE: md_valid=1 for exactly one cycle; next state IDLE.
- Latency: accept edge to md_valid cycle is XLEN+2 cycles (34 at XLEN=32).
- Signedness: MUL/MULH signed×signed; MULHSU signed×unsigned; MULHU, DIVU, REMU unsigned. Remainder sign follows the dividend.
- Fast paths, decided at accept, go straight to DONE (md_valid on the next cycle):
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return rs1.
  - Signed overflow (rs1 = most negative, rs2 = -1): DIV returns rs1; REM returns 0.
- stall = (state in MUL/DIV/FIX) || (state==IDLE && in_valid && is_muldiv). Stall is low in DONE, so the pipeline advances past the M-op on that edge.
- in_ready = (state==IDLE).
- Non-M instructions never touch the FSM and never stall.
- flush: any state returns to IDLE on the next edge; no md_valid. Flush in the accept cycle suppresses the accept.
- Reset, mid-operation or otherwise: state IDLE, counter 0, md_valid 0, md_result 0, internal accumulators 0.
- md_result holds its last value until the next DONE.

Decomposition:
- Shared package/include holds:
  - alu_op encodings;
  - funct3/funct7 constants, including FUNCT7_MULDIV=0000001 and FUNCT7_SRA=0100000;
  - M-op funct3 codes;
  - FSM state encoding.
- One natural sub-module, muldiv_iter: FSM, counter, accumulator, sign fix.
- The top level holds the combinational decoder and glue.

Test Plan:
- ADD/SUB/SRA/SLTU/LUI/BLTU instructions with in_valid=1 → alu_op 0000/0001/1100/1110/1111/1110; stall=0 and md_valid never asserted.
- MUL with rs1=-7 (0xFFFFFFF9), rs2=6 → stall for 34 cycles; md_valid one cycle later with md_result=0xFFFFFFD6; then state IDLE.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU with rs1=-1, rs2=2 → 0xFFFFFFFF.
- DIV with rs1=-20, rs2=6 → -3 (0xFFFFFFFD); REM of the same operands → -2 (0xFFFFFFFE); DIVU 0x80000000/0 → 0xFFFFFFFF with md_valid on the cycle after accept.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0; both on the fast path.
- flush asserted at cycle 10 of a DIV, then reset dropped low mid-MUL → each returns to IDLE with no md_valid, stall=0, md_result=0 after reset; the next MUL completes correctly.
